// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// opcodes, funct codes, ALU operations and FSM states.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_SLL = 4'd8;
    localparam logic [3:0] ALU_SRL = 4'd9;
    localparam logic [3:0] ALU_NOR = 4'd12;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_ALUWB  = 4'd7,
        S_EXEC_I = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd15
    } state_t;

    // States that sit on the memory handshake and may stall
    function automatic logic is_wait_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mips_mc_fsm_if.sv
// Control bundle between the multicycle FSM (master) and the
// datapath (slave): qualifiers in, enables and selects out.
interface mips_mc_fsm_if #(
    parameter int ALU_CTRL_W = 4,
    parameter int CNT_W      = 32
);
    logic [5:0]            Opcode;
    logic [5:0]            Funct;
    logic                  Zero;
    logic                  mem_ready;
    logic                  IorD;
    logic                  MemWrite;
    logic                  Mem_select;
    logic                  IRWrite;
    logic                  DataWrite;
    logic                  RDx_FF_en;
    logic                  RegDst;
    logic                  MemtoReg;
    logic                  RegWrite;
    logic                  ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [ALU_CTRL_W-1:0] ALUControl;
    logic                  ALUresult_en;
    logic                  PCSrc;
    logic                  Branch;
    logic                  PC_En;
    logic                  flag_J_type_out;
    logic                  trap;
    logic [3:0]            state;
    logic                  instr_retired;
    logic [CNT_W-1:0]      retired_cnt;

    modport master (
        input  Opcode, Funct, Zero, mem_ready,
        output IorD, MemWrite, Mem_select, IRWrite, DataWrite,
        output RDx_FF_en, RegDst, MemtoReg, RegWrite, ALUSrcA,
        output ALUSrcB, ALUControl, ALUresult_en, PCSrc, Branch,
        output PC_En, flag_J_type_out, trap, state,
        output instr_retired, retired_cnt
    );

    modport slave (
        output Opcode, Funct, Zero, mem_ready,
        input  IorD, MemWrite, Mem_select, IRWrite, DataWrite,
        input  RDx_FF_en, RegDst, MemtoReg, RegWrite, ALUSrcA,
        input  ALUSrcB, ALUControl, ALUresult_en, PCSrc, Branch,
        input  PC_En, flag_J_type_out, trap, state,
        input  instr_retired, retired_cnt
    );
endinterface

// File: rtl/mips_alu_decoder.sv
// R-type Funct to ALUControl map; legal is low for any funct
// the datapath cannot execute.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic [5:0]            funct,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  legal
);
    logic [3:0] code;

    always_comb begin
        code  = ALU_AND;
        legal = 1'b1;
        case (funct)
            FN_ADD:  code = ALU_ADD;
            FN_SUB:  code = ALU_SUB;
            FN_AND:  code = ALU_AND;
            FN_OR:   code = ALU_OR;
            FN_SLT:  code = ALU_SLT;
            FN_NOR:  code = ALU_NOR;
            FN_SLL:  code = ALU_SLL;
            FN_SRL:  code = ALU_SRL;
            default: legal = 1'b0;
        endcase
    end

    assign alu_ctrl = ALU_CTRL_W'(code);

endmodule

// File: rtl/mips_mc_fsm.sv
// Self-sequencing multicycle MIPS control FSM with memory
// handshake, wait-state watchdog, illegal-op trap and retire count.
module mips_mc_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int WAIT_MAX   = 15,
    parameter int CNT_W      = 32
) (
    input  logic          clk,
    input  logic          reset,
    mips_mc_fsm_if.master bus
);
    localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    state_t                st;
    state_t                nxt;
    state_t                ost;
    logic [WAIT_W-1:0]     wcnt;
    logic [CNT_W-1:0]      rcnt;
    logic [ALU_CTRL_W-1:0] r_alu;
    logic                  r_legal;
    logic                  wd_hit;
    logic                  retire;

    mips_alu_decoder #(
        .ALU_CTRL_W(ALU_CTRL_W)
    ) u_dec (
        .funct   (bus.Funct),
        .alu_ctrl(r_alu),
        .legal   (r_legal)
    );

    // A ready in the limit cycle wins over the watchdog
    assign wd_hit = (WAIT_MAX != 0) && is_wait_state(st)
                 && !bus.mem_ready
                 && (wcnt == WAIT_W'(WAIT_MAX));

    always_ff @(posedge clk) begin
        if (reset) st <= S_FETCH;
        else       st <= nxt;
    end

    always_ff @(posedge clk) begin
        if (reset)
            wcnt <= '0;
        else if (nxt != st)
            wcnt <= '0;
        else if (is_wait_state(st) && !bus.mem_ready)
            wcnt <= wcnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)       rcnt <= '0;
        else if (retire) rcnt <= rcnt + 1'b1;
    end

    always_comb begin
        nxt = st;
        unique case (st)
            S_FETCH: begin
                if (bus.mem_ready) nxt = S_DECODE;
                else if (wd_hit)   nxt = S_TRAP;
            end
            S_DECODE: begin
                unique case (1'b1)
                    (bus.Opcode == OP_R):
                        nxt = r_legal ? S_EXEC_R : S_TRAP;
                    (bus.Opcode == OP_LW),
                    (bus.Opcode == OP_SW):
                        nxt = S_MEMADR;
                    (bus.Opcode == OP_BEQ),
                    (bus.Opcode == OP_BNE):
                        nxt = S_BRANCH;
                    (bus.Opcode == OP_ADDI),
                    (bus.Opcode == OP_ORI):
                        nxt = S_EXEC_I;
                    (bus.Opcode == OP_J):
                        nxt = S_JUMP;
                    default:
                        nxt = S_TRAP;
                endcase
            end
            S_MEMADR:
                nxt = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (bus.mem_ready) nxt = S_MEMWB;
                else if (wd_hit)   nxt = S_TRAP;
            end
            S_MEMWR: begin
                if (bus.mem_ready) nxt = S_FETCH;
                else if (wd_hit)   nxt = S_TRAP;
            end
            S_EXEC_R: nxt = S_ALUWB;
            S_EXEC_I: nxt = S_IWB;
            S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP:
                nxt = S_FETCH;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_TRAP;
        endcase
    end

    // Reset shows the FETCH decode with every enable held off
    assign ost = reset ? S_FETCH : st;

    always_comb begin
        bus.IorD            = 1'b0;
        bus.MemWrite        = 1'b0;
        bus.Mem_select      = 1'b0;
        bus.IRWrite         = 1'b0;
        bus.DataWrite       = 1'b0;
        bus.RDx_FF_en       = 1'b0;
        bus.RegDst          = 1'b0;
        bus.MemtoReg        = 1'b0;
        bus.RegWrite        = 1'b0;
        bus.ALUSrcA         = 1'b0;
        bus.ALUSrcB         = 2'b00;
        bus.ALUControl      = '0;
        bus.ALUresult_en    = 1'b0;
        bus.PCSrc           = 1'b0;
        bus.Branch          = 1'b0;
        bus.PC_En           = 1'b0;
        bus.flag_J_type_out = 1'b0;
        bus.trap            = 1'b0;
        retire              = 1'b0;
        unique case (ost)
            S_FETCH: begin
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = ALU_CTRL_W'(ALU_ADD);
                bus.IRWrite    = bus.mem_ready;
                bus.PC_En      = bus.mem_ready;
            end
            S_DECODE: begin
                bus.ALUSrcB      = 2'b11;
                bus.ALUControl   = ALU_CTRL_W'(ALU_ADD);
                bus.ALUresult_en = 1'b1;
                bus.RDx_FF_en    = 1'b1;
            end
            S_MEMADR: begin
                bus.ALUSrcA      = 1'b1;
                bus.ALUSrcB      = 2'b10;
                bus.ALUControl   = ALU_CTRL_W'(ALU_ADD);
                bus.ALUresult_en = 1'b1;
            end
            S_MEMRD: begin
                bus.IorD       = 1'b1;
                bus.Mem_select = 1'b1;
                bus.DataWrite  = bus.mem_ready;
            end
            S_MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
                retire       = 1'b1;
            end
            S_MEMWR: begin
                bus.IorD       = 1'b1;
                bus.Mem_select = 1'b1;
                bus.MemWrite   = 1'b1;
                retire         = bus.mem_ready;
            end
            S_EXEC_R: begin
                bus.ALUSrcA      = 1'b1;
                bus.ALUControl   = r_alu;
                bus.ALUresult_en = 1'b1;
            end
            S_ALUWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
                retire       = 1'b1;
            end
            S_EXEC_I: begin
                bus.ALUSrcA      = 1'b1;
                bus.ALUSrcB      = 2'b10;
                bus.ALUControl   = (bus.Opcode == OP_ORI)
                                 ? ALU_CTRL_W'(ALU_OR)
                                 : ALU_CTRL_W'(ALU_ADD);
                bus.ALUresult_en = 1'b1;
            end
            S_IWB: begin
                bus.RegWrite = 1'b1;
                retire       = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = ALU_CTRL_W'(ALU_SUB);
                bus.Branch     = 1'b1;
                bus.PCSrc      = 1'b1;
                bus.PC_En      = (bus.Opcode == OP_BNE)
                               ? !bus.Zero : bus.Zero;
                retire         = 1'b1;
            end
            S_JUMP: begin
                bus.flag_J_type_out = 1'b1;
                bus.PC_En           = 1'b1;
                retire              = 1'b1;
            end
            S_TRAP:  bus.trap = 1'b1;
            default: bus.trap = 1'b1;
        endcase
        if (reset) begin
            bus.MemWrite     = 1'b0;
            bus.IRWrite      = 1'b0;
            bus.DataWrite    = 1'b0;
            bus.RegWrite     = 1'b0;
            bus.PC_En        = 1'b0;
            bus.ALUresult_en = 1'b0;
            bus.RDx_FF_en    = 1'b0;
            retire           = 1'b0;
        end
    end

    assign bus.state         = st;
    assign bus.instr_retired = retire;
    assign bus.retired_cnt   = rcnt;

endmodule

// File: tb/tb_mips_mc_fsm.sv
// Directed bench for mips_mc_fsm: walks each instruction class,
// the memory stall, watchdog, illegal-op trap and reset paths.
module tb_mips_mc_fsm;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mips_mc_fsm_if #(.ALU_CTRL_W(4), .CNT_W(32)) bus ();

    mips_mc_fsm #(
        .ALU_CTRL_W(4),
        .WAIT_MAX  (15),
        .CNT_W     (32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enables();
        return 32'({bus.MemWrite, bus.IRWrite, bus.DataWrite,
                    bus.RegWrite, bus.PC_En, bus.ALUresult_en,
                    bus.RDx_FF_en, bus.instr_retired});
    endfunction

    initial begin
        reset         = 1'b1;
        bus.Opcode    = 6'b000000;
        bus.Funct     = 6'b100000;
        bus.Zero      = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_trap", 32'(bus.trap), 0);
        chk("rst_cnt", bus.retired_cnt, 0);
        chk("rst_pcen", 32'(bus.PC_En), 0);
        chk("rst_irw", 32'(bus.IRWrite), 0);
        chk("rst_srcb", 32'(bus.ALUSrcB), 1);

        // R-type ADD
        reset = 1'b0;
        #1;
        chk("r_f_irw", 32'(bus.IRWrite), 1);
        chk("r_f_pcen", 32'(bus.PC_En), 1);
        chk("r_f_alu", 32'(bus.ALUControl), 2);
        tick();
        chk("r_dec_st", 32'(bus.state), 1);
        chk("r_dec_srcb", 32'(bus.ALUSrcB), 3);
        chk("r_dec_rdx", 32'(bus.RDx_FF_en), 1);
        tick();
        chk("r_ex_st", 32'(bus.state), 6);
        chk("r_ex_alu", 32'(bus.ALUControl), 2);
        chk("r_ex_srca", 32'(bus.ALUSrcA), 1);
        tick();
        chk("r_wb_st", 32'(bus.state), 7);
        chk("r_wb_rw", 32'(bus.RegWrite), 1);
        chk("r_wb_rd", 32'(bus.RegDst), 1);
        chk("r_wb_ret", 32'(bus.instr_retired), 1);
        tick();
        chk("r_cnt", bus.retired_cnt, 1);
        chk("r_back", 32'(bus.state), 0);

        // LW with three stall cycles in MEMRD
        bus.Opcode = 6'b100011;
        tick();
        tick();
        chk("lw_adr_st", 32'(bus.state), 2);
        chk("lw_adr_srcb", 32'(bus.ALUSrcB), 2);
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("lw_rd_st", 32'(bus.state), 3);
        chk("lw_rd_iord", 32'(bus.IorD), 1);
        chk("lw_stall1", 32'(bus.DataWrite), 0);
        tick();
        chk("lw_stall2", 32'(bus.DataWrite), 0);
        tick();
        chk("lw_stall3", 32'(bus.DataWrite), 0);
        chk("lw_stall_st", 32'(bus.state), 3);
        bus.mem_ready = 1'b1;
        #1;
        chk("lw_dw", 32'(bus.DataWrite), 1);
        tick();
        chk("lw_wb_st", 32'(bus.state), 4);
        chk("lw_wb_m2r", 32'(bus.MemtoReg), 1);
        chk("lw_wb_rw", 32'(bus.RegWrite), 1);
        tick();
        chk("lw_cnt", bus.retired_cnt, 2);

        // SW
        bus.Opcode = 6'b101011;
        tick();
        tick();
        tick();
        chk("sw_st", 32'(bus.state), 5);
        chk("sw_mw", 32'(bus.MemWrite), 1);
        chk("sw_ret", 32'(bus.instr_retired), 1);
        tick();
        chk("sw_cnt", bus.retired_cnt, 3);

        // BEQ taken, BNE not taken, both with Zero=1
        bus.Opcode = 6'b000100;
        bus.Zero   = 1'b1;
        tick();
        tick();
        chk("beq_st", 32'(bus.state), 10);
        chk("beq_pcen", 32'(bus.PC_En), 1);
        chk("beq_pcsrc", 32'(bus.PCSrc), 1);
        chk("beq_alu", 32'(bus.ALUControl), 6);
        tick();
        bus.Opcode = 6'b000101;
        tick();
        tick();
        chk("bne_pcen", 32'(bus.PC_En), 0);
        chk("bne_ret", 32'(bus.instr_retired), 1);
        tick();
        chk("br_cnt", bus.retired_cnt, 5);

        // ORI
        bus.Opcode = 6'b001101;
        tick();
        tick();
        chk("ori_st", 32'(bus.state), 8);
        chk("ori_alu", 32'(bus.ALUControl), 1);
        tick();
        chk("iwb_st", 32'(bus.state), 9);
        chk("iwb_rd", 32'(bus.RegDst), 0);
        tick();

        // J
        bus.Opcode = 6'b000010;
        tick();
        tick();
        chk("j_st", 32'(bus.state), 11);
        chk("j_flag", 32'(bus.flag_J_type_out), 1);
        chk("j_pcen", 32'(bus.PC_En), 1);
        tick();
        chk("j_cnt", bus.retired_cnt, 7);

        // Reset while stalled in MEMRD
        bus.Opcode = 6'b100011;
        tick();
        tick();
        tick();
        bus.mem_ready = 1'b0;
        #1;
        chk("mr_st", 32'(bus.state), 3);
        reset = 1'b1;
        #1;
        chk("mr_rst_pcen", 32'(bus.PC_En), 0);
        chk("mr_rst_iord", 32'(bus.IorD), 0);
        tick();
        chk("mr_rst_st", 32'(bus.state), 0);
        chk("mr_rst_trap", 32'(bus.trap), 0);
        chk("mr_rst_cnt", bus.retired_cnt, 0);

        // Watchdog: ready on cycle 16 rescues the fetch
        reset      = 1'b0;
        bus.Opcode = 6'b000010;
        for (int i = 0; i < 15; i++) tick();
        chk("wd_hold_st", 32'(bus.state), 0);
        bus.mem_ready = 1'b1;
        tick();
        chk("wd_save_st", 32'(bus.state), 1);
        chk("wd_save_trap", 32'(bus.trap), 0);
        tick();
        tick();
        chk("wd_j_cnt", bus.retired_cnt, 1);

        // Watchdog expiry
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("wd_pre_st", 32'(bus.state), 0);
        tick();
        chk("wd_trap_st", 32'(bus.state), 15);
        chk("wd_trap", 32'(bus.trap), 1);

        // Illegal opcode
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.Opcode    = 6'b111111;
        tick();
        chk("ill_dec", 32'(bus.state), 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("ill_st", 32'(bus.state), 15);
            chk("ill_trap", 32'(bus.trap), 1);
            chk("ill_en", enables(), 0);
        end

        // Illegal R-type funct
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        bus.Opcode = 6'b000000;
        bus.Funct  = 6'b111111;
        tick();
        tick();
        chk("illf_st", 32'(bus.state), 15);
        chk("illf_cnt", bus.retired_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
